// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard interlock and flush sequencer for a fetch/decode/execute/writeback pipeline.
// Define PIPE_HAZARD_PERF_EN to add the stall-cycle and redirect performance counters.
module pipe_hazard_ctrl #(
   parameter int PEND_W       = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dec_valid,
   input  logic [4:0] dec_rs1,
   input  logic [4:0] dec_rs2,
   input  logic       dec_rs1_used,
   input  logic       dec_rs2_used,
   input  logic [4:0] dec_rd,
   input  logic       dec_wr_enable,
   input  logic [4:0] wb_wr_addr,
   input  logic       wb_wr_enable,
   input  logic       ex_redirect,
   output logic       fetch_stall,
   output logic       decode_stall,
   output logic       decode_flush,
   output logic       fetch_flush,
   output logic       issue,
   output logic [1:0] state
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam logic [1:0]        RUN        = 2'b00;
   localparam logic [1:0]        STALL      = 2'b01;
   localparam logic [1:0]        FLUSH      = 2'b10;
   localparam logic [PEND_W-1:0] PEND_MAX   = '1;
   localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   logic [PEND_W-1:0] pend [32];
   logic [1:0]        state_q, state_d;
   logic [2:0]        flush_cnt_q, flush_cnt_d;
   logic              hazard, in_flush, issue_go;

   // Hazard looks only at registered counts; a same-cycle writeback is not yet visible.
   always_comb begin
      hazard = dec_valid & ((dec_rs1_used & (pend[dec_rs1] != '0)) |
                            (dec_rs2_used & (pend[dec_rs2] != '0)) |
                            (dec_wr_enable & (pend[dec_rd] == PEND_MAX)));
      in_flush = (state_q == FLUSH);
      issue_go = dec_valid & ~hazard & ~ex_redirect & ~in_flush;
   end

   // pend[0] is only ever cleared, so x0 never reports a hazard.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) pend[r] <= '0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            if ((issue_go && dec_wr_enable && dec_rd == 5'(r)) &&
                !(wb_wr_enable && wb_wr_addr == 5'(r)))
               pend[r] <= pend[r] + 1'b1;
            else if ((wb_wr_enable && wb_wr_addr == 5'(r)) && pend[r] != '0 &&
                     !(issue_go && dec_wr_enable && dec_rd == 5'(r)))
               pend[r] <= pend[r] - 1'b1;
         end
      end
   end

   assert property (@(posedge clk) disable iff (rst)
      (wb_wr_enable && wb_wr_addr != 5'd0 &&
       !(issue_go && dec_wr_enable && dec_rd == wb_wr_addr)) |-> (pend[wb_wr_addr] != '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         RUN: begin
            if (ex_redirect) begin
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_LOAD;
            end else if (hazard) begin
               state_d = STALL;
            end
         end
         STALL: begin
            if (ex_redirect) begin
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_LOAD;
            end else if (!hazard) begin
               state_d = RUN;
            end
         end
         FLUSH: begin
            if (ex_redirect) flush_cnt_d = FLUSH_LOAD;
            else if (flush_cnt_q == 3'd0) state_d = RUN;
            else flush_cnt_d = flush_cnt_q - 3'd1;
         end
         default: state_d = RUN;
      endcase
   end

   // Outputs are forced low while reset is held.
   always_comb begin
      issue        = 1'b0;
      fetch_stall  = 1'b0;
      decode_stall = 1'b0;
      fetch_flush  = 1'b0;
      decode_flush = 1'b0;
      state        = RUN;
      if (!rst) begin
         issue        = issue_go;
         fetch_stall  = hazard & ~ex_redirect & ~in_flush;
         decode_stall = hazard & ~ex_redirect & ~in_flush;
         fetch_flush  = ex_redirect | in_flush;
         decode_flush = ex_redirect | in_flush | hazard;
         state        = state_q;
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (fetch_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (ex_redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a count-based scoreboard model.
// Optional perf counters are checked when PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;
   localparam int PEND_W       = 2;
   localparam int FLUSH_CYCLES = 2;
   localparam int PMAX         = (1 << PEND_W) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       dec_valid, dec_rs1_used, dec_rs2_used, dec_wr_enable;
   logic [4:0] dec_rs1, dec_rs2, dec_rd, wb_wr_addr;
   logic       wb_wr_enable, ex_redirect;
   logic       fetch_stall, decode_stall, decode_flush, fetch_flush, issue;
   logic [1:0] state;
`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.PEND_W(PEND_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd),
      .dec_wr_enable(dec_wr_enable), .wb_wr_addr(wb_wr_addr), .wb_wr_enable(wb_wr_enable),
      .ex_redirect(ex_redirect), .fetch_stall(fetch_stall), .decode_stall(decode_stall),
      .decode_flush(decode_flush), .fetch_flush(fetch_flush), .issue(issue), .state(state)
`ifdef PIPE_HAZARD_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: in-flight write counts per register, remaining squash cycles,
   // and whether the previous cycle was a stall (which is what the STALL state reports).
   int m_pend [32];
   int m_flush_rem;
   bit m_prev_stall;
   int m_perf_stall, m_perf_flush;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
      m_flush_rem  = 0;
      m_prev_stall = 1'b0;
      m_perf_stall = 0;
      m_perf_flush = 0;
   endtask

   task automatic set_dec(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit wr);
      dec_valid     = v;
      dec_rs1       = 5'(rs1);
      dec_rs1_used  = u1;
      dec_rs2       = 5'(rs2);
      dec_rs2_used  = u2;
      dec_rd        = 5'(rd);
      dec_wr_enable = wr;
   endtask

   task automatic set_wb(input bit en, input int addr);
      wb_wr_enable = en;
      wb_wr_addr   = 5'(addr);
   endtask

   // One clock: inputs are already applied; compare at the falling edge, then advance the model.
   task automatic step(input string tag);
      bit hz, infl, e_issue, e_stall, e_ff, e_df;
      int e_state, inc_r, dec_r;
      infl = (m_flush_rem > 0);
      hz = dec_valid &&
           ((dec_rs1_used && dec_rs1 != 0 && m_pend[dec_rs1] > 0) ||
            (dec_rs2_used && dec_rs2 != 0 && m_pend[dec_rs2] > 0) ||
            (dec_wr_enable && dec_rd != 0 && m_pend[dec_rd] == PMAX));
      if (rst) begin
         e_issue = 0; e_stall = 0; e_ff = 0; e_df = 0; e_state = 0;
      end else begin
         e_issue = dec_valid && !hz && !ex_redirect && !infl;
         e_stall = hz && !ex_redirect && !infl;
         e_ff    = ex_redirect || infl;
         e_df    = e_ff || hz;
         e_state = infl ? 2 : (m_prev_stall ? 1 : 0);
      end
      @(negedge clk);
      check($sformatf("%s.issue", tag), 32'(issue), 32'(e_issue));
      check($sformatf("%s.fetch_stall", tag), 32'(fetch_stall), 32'(e_stall));
      check($sformatf("%s.decode_stall", tag), 32'(decode_stall), 32'(e_stall));
      check($sformatf("%s.fetch_flush", tag), 32'(fetch_flush), 32'(e_ff));
      check($sformatf("%s.decode_flush", tag), 32'(decode_flush), 32'(e_df));
      check($sformatf("%s.state", tag), 32'(state), 32'(e_state));
`ifdef PIPE_HAZARD_PERF_EN
      check($sformatf("%s.perf_stall", tag), perf_stall_cnt, 32'(m_perf_stall));
      check($sformatf("%s.perf_flush", tag), perf_flush_cnt, 32'(m_perf_flush));
`endif
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         inc_r = (e_issue && dec_wr_enable && dec_rd != 0) ? int'(dec_rd) : -1;
         dec_r = (wb_wr_enable && wb_wr_addr != 0) ? int'(wb_wr_addr) : -1;
         if (inc_r != dec_r) begin
            if (inc_r > 0) m_pend[inc_r]++;
            if (dec_r > 0 && m_pend[dec_r] > 0) m_pend[dec_r]--;
         end
         if (ex_redirect) m_flush_rem = FLUSH_CYCLES;
         else if (m_flush_rem > 0) m_flush_rem--;
         m_prev_stall = e_stall;
         if (e_stall) m_perf_stall++;
         if (ex_redirect) m_perf_flush++;
      end
      #1;
   endtask

   task automatic idle();
      set_dec(0, 0, 0, 0, 0, 0, 0);
      set_wb(0, 0);
      ex_redirect = 0;
   endtask

   initial begin
      int pl[$];
      model_reset();
      rst = 1'b1;
      // Outputs must stay low under reset even with active inputs.
      set_dec(1, 0, 0, 0, 0, 4, 1);
      set_wb(0, 0);
      ex_redirect = 1;
      step("rst0");
      step("rst1");
      rst = 1'b0;
      idle();
      step("post_rst");

      // RAW: ADDI x5 then ADD x6,x5,x1
      set_dec(1, 0, 1, 0, 0, 5, 1); step("raw_addi");
      set_dec(1, 5, 1, 1, 1, 6, 1); step("raw_stall0");
      step("raw_stall1");
      set_wb(1, 5); step("raw_wb_same");
      set_wb(0, 0); step("raw_release");
      idle(); set_wb(1, 6); step("raw_drain");
      set_wb(0, 0);

      // x0 reads and writes never hazard
      for (int i = 0; i < 4; i++) begin
         set_dec(1, 0, 1, 0, 1, 0, 1);
         step($sformatf("x0_%0d", i));
      end

      // WAW: three writers of x7 in flight, fourth blocks until a writeback retires
      for (int i = 0; i < 3; i++) begin
         set_dec(1, 0, 0, 0, 0, 7, 1);
         step($sformatf("waw_fill%0d", i));
      end
      step("waw_block");
      set_wb(1, 7); step("waw_wb_same");
      set_wb(0, 0); step("waw_release");

      // Redirect while stalled on x7
      set_dec(1, 7, 1, 0, 0, 8, 1); step("rd_stall");
      ex_redirect = 1; step("rd_redirect");
      ex_redirect = 0; step("rd_flush1");
      step("rd_flush2");
      idle(); step("rd_run");

      // Drain x7 (three outstanding) and exercise same-cycle inc/dec on x9
      for (int i = 0; i < 3; i++) begin
         set_wb(1, 7); step($sformatf("drain7_%0d", i));
      end
      set_wb(0, 0);
      set_dec(1, 0, 0, 0, 0, 9, 1); step("x9_first");
      set_wb(1, 9); step("x9_same");
      set_wb(0, 0); set_dec(1, 9, 1, 0, 0, 1, 1); step("x9_still_pending");
      set_wb(1, 9); step("x9_wb");
      set_wb(0, 0); step("x9_release");
      idle(); step("x9_idle");

      // Randomized traffic over a small register set so hazards are frequent
      for (int c = 0; c < 3000; c++) begin
         if (!(m_prev_stall && $urandom_range(0, 4) != 0)) begin
            set_dec($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                    $urandom_range(0, 1) == 1);
         end
         pl.delete();
         for (int r = 1; r < 32; r++) if (m_pend[r] > 0) pl.push_back(r);
         if (pl.size() > 0 && $urandom_range(0, 2) == 0)
            set_wb(1, pl[$urandom_range(0, pl.size() - 1)]);
         else
            set_wb(0, 0);
         ex_redirect = ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 299) == 0);
         step($sformatf("rnd%0d", c));
         rst = 1'b0;
      end

      // Reset mid-operation with pend[3]=2 and state FLUSH
      idle(); rst = 1'b1; step("mr_pre_rst");
      rst = 1'b0;
      set_dec(1, 0, 0, 0, 0, 3, 1); step("mr_w3a");
      step("mr_w3b");
      idle(); ex_redirect = 1; step("mr_redirect");
      ex_redirect = 0; rst = 1'b1; step("mr_rst");
      rst = 1'b0; set_dec(1, 3, 1, 3, 1, 3, 1); step("mr_after");
      idle(); step("mr_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
